clock_set_ctrl: RTL and testbench

Mode/sequencing controller for the 24-hour digital clock datapath (sec/min/hour BCD counters, 7-segment scanner, hourly chime). Debounces the two user buttons and runs a mode FSM that stops and starts the clock. It issues single-cycle increment strobes to the minute and hour counters, and holds an alarm time with its own compare and alarm output. It also drives per-digit blink masks to the scanner.

---
 rtl/clock_set_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Mode/sequencing controller for the 24h clock: button debounce, set-mode FSM,
// set strobes, alarm time/compare and blink masks. Define AUTO_REPEAT_EN for held-inc repeat.
module clock_set_ctrl #(
  parameter int DEB_CYCLES  = 20,
  parameter int ALARM_SECS  = 30,
  parameter int HOLD_CYCLES = 64,
  parameter int REP_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hour,
  input  logic [3:0] cur_min_ones,
  input  logic [3:0] cur_min_tens,
  input  logic       cur_sec_zero,
  output logic       run_en,
  output logic       sec_clr,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       disp_alarm,
  output logic [4:0] alarm_hour,
  output logic [3:0] alarm_min_ones,
  output logic [3:0] alarm_min_tens,
  output logic [5:0] blank_mask,
  output logic       alarm_en,
  output logic       alarm_out
);

  typedef enum logic [2:0] {RUN, SET_HOUR, SET_MIN, SET_ALM_HOUR, SET_ALM_MIN} state_t;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_SECS);

  state_t        state, nxt_state;
  logic          blink, nxt_blink;
  logic [1:0]    raw, sync1, sync2, stable, press;  // bit0 = mode, bit1 = inc
  logic [DW-1:0] deb_cnt [2];
  logic          mode_evt, inc_evt, rpt_evt, alarm_hit;
  logic [AW-1:0] alarm_cnt;

  assign raw = {btn_inc, btn_mode};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          stable[i]  <= sync2[i];
          press[i]   <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2((HOLD_CYCLES > REP_CYCLES ? HOLD_CYCLES : REP_CYCLES) + 1);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYCLES - 1);
  logic [RW-1:0] rpt_cnt;
  logic          rpt_active, rpt_hold;

  // A fresh press or any mode press restarts the hold window.
  assign rpt_hold = stable[1] && (state != RUN) && !press[0] && !press[1];
  assign rpt_evt  = rpt_hold && (rpt_cnt == (rpt_active ? REP_LAST : HOLD_LAST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt    <= '0;
      rpt_active <= 1'b0;
    end else if (!rpt_hold) begin
      rpt_cnt    <= '0;
      rpt_active <= 1'b0;
    end else if (rpt_evt) begin
      rpt_cnt    <= '0;
      rpt_active <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rpt_evt = 1'b0;
`endif

  // Presses while the alarm sounds only silence it; mode beats inc in the same cycle.
  assign mode_evt = press[0] && !alarm_out;
  assign inc_evt  = (press[1] || rpt_evt) && !press[0] && !alarm_out;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    nxt_state = state;
    if (mode_evt) begin
      case (state)
        RUN:          nxt_state = SET_HOUR;
        SET_HOUR:     nxt_state = SET_MIN;
        SET_MIN:      nxt_state = SET_ALM_HOUR;
        SET_ALM_HOUR: nxt_state = SET_ALM_MIN;
        default:      nxt_state = RUN;
      endcase
    end
    nxt_blink = blink;
    if (nxt_state == RUN)             nxt_blink = 1'b0;
    else if (tick_1hz && state != RUN) nxt_blink = ~blink;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= RUN;
      blink          <= 1'b0;
      run_en         <= 1'b1;
      sec_clr        <= 1'b0;
      min_inc        <= 1'b0;
      hour_inc       <= 1'b0;
      disp_alarm     <= 1'b0;
      blank_mask     <= '0;
      alarm_en       <= 1'b0;
      alarm_hour     <= '0;
      alarm_min_ones <= '0;
      alarm_min_tens <= '0;
    end else begin
      state      <= nxt_state;
      blink      <= nxt_blink;
      run_en     <= !(nxt_state inside {SET_HOUR, SET_MIN});
      disp_alarm <= nxt_state inside {SET_ALM_HOUR, SET_ALM_MIN};
      sec_clr    <= mode_evt && (state == SET_MIN);
      hour_inc   <= inc_evt && (state == SET_HOUR);
      min_inc    <= inc_evt && (state == SET_MIN);
      case (nxt_state)
        SET_HOUR:     blank_mask <= {nxt_blink, nxt_blink, 4'b0000};
        SET_MIN:      blank_mask <= {2'b00, nxt_blink, nxt_blink, 2'b00};
        SET_ALM_HOUR: blank_mask <= {nxt_blink, nxt_blink, 4'b0011};
        SET_ALM_MIN:  blank_mask <= {2'b00, nxt_blink, nxt_blink, 2'b11};
        default:      blank_mask <= '0;
      endcase
      if (inc_evt) begin
        case (state)
          RUN:          alarm_en <= ~alarm_en;
          SET_ALM_HOUR: alarm_hour <= (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
          SET_ALM_MIN: begin
            if (alarm_min_ones == 4'd9) begin
              alarm_min_ones <= 4'd0;
              alarm_min_tens <= (alarm_min_tens == 4'd5) ? 4'd0 : alarm_min_tens + 4'd1;
            end else begin
              alarm_min_ones <= alarm_min_ones + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign alarm_hit = alarm_en && !(state inside {SET_HOUR, SET_MIN}) && cur_sec_zero &&
                     (cur_hour == alarm_hour) && (cur_min_ones == alarm_min_ones) &&
                     (cur_min_tens == alarm_min_tens);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_out <= 1'b0;
      alarm_cnt <= '0;
    end else if (alarm_out && (press != 2'b00)) begin
      alarm_out <= 1'b0;
      alarm_cnt <= '0;
    end else if (tick_1hz) begin
      if (alarm_out) begin
        if (alarm_cnt <= AW'(1)) begin
          alarm_out <= 1'b0;
          alarm_cnt <= '0;
        end else begin
          alarm_cnt <= alarm_cnt - 1'b1;
        end
      end else if (alarm_hit) begin
        alarm_out <= 1'b1;
        alarm_cnt <= ALARM_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: randomized button/alarm stimulus
// compared against a high-level model of modes, alarm time and strobe counts.
module tb_clock_set_ctrl;
  localparam int DEB = 4;
  localparam int ASECS = 3;
  localparam int LAT = DEB + 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [3:0] cur_min_ones = '0, cur_min_tens = '0;
  logic cur_sec_zero = 1'b0;
  logic run_en, sec_clr, min_inc, hour_inc, disp_alarm, alarm_en, alarm_out;
  logic [4:0] alarm_hour;
  logic [3:0] alarm_min_ones, alarm_min_tens;
  logic [5:0] blank_mask;

  int total = 0;
  int bad = 0;

  // Model: state index 0..4 in mode order, alarm time as plain integers.
  int m_state = 0;
  int m_ah = 0, m_am = 0;
  bit m_alarm_en = 0, m_ph = 0, m_alarm_out = 0;
  int exp_hour = 0, exp_min = 0, exp_secclr = 0;
  int n_hour = 0, n_min = 0, n_secclr = 0;

  clock_set_ctrl #(.DEB_CYCLES(DEB), .ALARM_SECS(ASECS), .HOLD_CYCLES(64), .REP_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min_ones(cur_min_ones), .cur_min_tens(cur_min_tens),
    .cur_sec_zero(cur_sec_zero), .run_en(run_en), .sec_clr(sec_clr), .min_inc(min_inc),
    .hour_inc(hour_inc), .disp_alarm(disp_alarm), .alarm_hour(alarm_hour),
    .alarm_min_ones(alarm_min_ones), .alarm_min_tens(alarm_min_tens), .blank_mask(blank_mask),
    .alarm_en(alarm_en), .alarm_out(alarm_out));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hour_inc) n_hour++;
    if (min_inc) n_min++;
    if (sec_clr) n_secclr++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] obs_vec();
    return {run_en, disp_alarm, alarm_en, alarm_hour, alarm_min_tens, alarm_min_ones,
            blank_mask, alarm_out};
  endfunction

  function automatic logic [22:0] exp_vec();
    logic [5:0] bm;
    case (m_state)
      0: bm = 6'b000000;
      1: bm = {m_ph, m_ph, 4'b0000};
      2: bm = {2'b00, m_ph, m_ph, 2'b00};
      3: bm = {m_ph, m_ph, 4'b0011};
      default: bm = {2'b00, m_ph, m_ph, 2'b11};
    endcase
    return {(m_state != 1 && m_state != 2), (m_state >= 3), m_alarm_en, 5'(m_ah),
            4'(m_am / 10), 4'(m_am % 10), bm, m_alarm_out};
  endfunction

  function automatic void model_press(bit mode, bit inc);
    if (m_alarm_out) begin
      m_alarm_out = 0;
      return;
    end
    if (mode) begin
      if (m_state == 2) exp_secclr++;
      m_state = (m_state + 1) % 5;
      if (m_state == 0) m_ph = 0;
    end else if (inc) begin
      case (m_state)
        0: m_alarm_en = !m_alarm_en;
        1: exp_hour++;
        2: exp_min++;
        3: m_ah = (m_ah + 1) % 24;
        default: m_am = (m_am + 1) % 60;
      endcase
    end
  endfunction

  // Clean press: held long enough to debounce, then released and settled.
  task automatic press_btn(input bit mode, input bit inc);
    btn_mode = mode;
    btn_inc = inc;
    repeat (LAT + 1) step();
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (LAT + 1) step();
    model_press(mode, inc);
  endtask

  task automatic tick_pulse();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    if (m_state != 0) m_ph = !m_ph;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      total++;
      if ({run_en, blank_mask, sec_clr, min_inc, hour_inc, alarm_out, alarm_en, disp_alarm}
          !== {1'b1, 6'b0, 6'b0}) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: got run=%b blank=%b strobes=%b%b%b out=%b en=%b disp=%b",
                 i, run_en, blank_mask, sec_clr, min_inc, hour_inc, alarm_out, alarm_en, disp_alarm);
      end
    end
  endtask

  task automatic test_debounce();
    int glen;
    for (int t = 0; t < 3; t++) begin
      glen = (t == 0) ? DEB - 1 : int'($urandom_range(1, DEB - 1));
      btn_inc = 1'b1;
      repeat (glen) step();
      btn_inc = 1'b0;
      repeat (LAT + 4) step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL glitch_len%0d: got %h want %h", glen, obs_vec(), exp_vec());
      end
    end
    btn_inc = 1'b1;
    repeat (LAT - 1) step();
    total++;
    if (alarm_en !== 1'b0) begin
      bad++;
      $display("FAIL deb_early: got alarm_en=%b want 0", alarm_en);
    end
    step();
    total++;
    if (alarm_en !== 1'b1) begin
      bad++;
      $display("FAIL deb_latency: got alarm_en=%b want 1", alarm_en);
    end
    repeat (10 - LAT) step();
    btn_inc = 1'b0;
    repeat (LAT + 1) step();
    model_press(0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL deb_hold10: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_set_hour();
    press_btn(1, 0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL enter_set_hour: got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 2; i++) begin
      press_btn(0, 1);
      total++;
      if (n_hour !== exp_hour || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL hour_inc%0d: got cnt=%0d vec=%h want cnt=%0d vec=%h",
                 i, n_hour, obs_vec(), exp_hour, exp_vec());
      end
    end
  endtask

  task automatic test_blink();
    for (int i = 0; i < 4; i++) begin
      tick_pulse();
      total++;
      if (blank_mask[5:4] !== {m_ph, m_ph} || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL blink%0d: got mask=%b want ph=%b", i, blank_mask, m_ph);
      end
      repeat (3) step();
    end
  endtask

  task automatic test_alarm_min();
    for (int i = 0; i < 3; i++) begin
      press_btn(1, 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL mode_to_alm_min%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (n_secclr !== 1 || exp_secclr !== 1) begin
      bad++;
      $display("FAIL sec_clr_once: got %0d want 1", n_secclr);
    end
    repeat (58) press_btn(0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL alarm_0_58: got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      press_btn(0, 1);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL alarm_min_wrap%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if ({alarm_hour, alarm_min_tens, alarm_min_ones, disp_alarm} !== {5'd0, 4'd0, 4'd1, 1'b1}) begin
      bad++;
      $display("FAIL alarm_0_01: got %0d:%0d%0d disp=%b want 0:01 disp=1",
               alarm_hour, alarm_min_tens, alarm_min_ones, disp_alarm);
    end
  endtask

  task automatic test_simultaneous();
    repeat (3) press_btn(1, 0);
    press_btn(1, 1);
    total++;
    if (obs_vec() !== exp_vec() || n_min !== exp_min || n_secclr !== exp_secclr ||
        m_state != 3) begin
      bad++;
      $display("FAIL mode_beats_inc: got vec=%h min=%0d clr=%0d want vec=%h min=%0d clr=%0d",
               obs_vec(), n_min, n_secclr, exp_vec(), exp_min, exp_secclr);
    end
  endtask

  task automatic test_random_alarm_set();
    int n;
    n = int'($urandom_range(1, 30));
    repeat (n) press_btn(0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL rand_alm_hour n=%0d: got %h want %h", n, obs_vec(), exp_vec());
    end
    repeat ((7 - m_ah + 24) % 24) press_btn(0, 1);
    press_btn(1, 0);
    n = int'($urandom_range(1, 70));
    repeat (n) press_btn(0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL rand_alm_min n=%0d: got %h want %h", n, obs_vec(), exp_vec());
    end
    repeat ((30 - m_am + 60) % 60) press_btn(0, 1);
    press_btn(1, 0);
    total++;
    if (obs_vec() !== exp_vec() || alarm_hour !== 5'd7 || alarm_min_tens !== 4'd3 ||
        alarm_min_ones !== 4'd0 || alarm_en !== 1'b1) begin
      bad++;
      $display("FAIL alarm_7_30_run: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_alarm();
    cur_hour = 5'd7;
    cur_min_tens = 4'd3;
    cur_min_ones = 4'd1;
    cur_sec_zero = 1'b1;
    tick_pulse();
    total++;
    if (alarm_out !== 1'b0) begin
      bad++;
      $display("FAIL alarm_mismatch: got %b want 0", alarm_out);
    end
    cur_min_ones = 4'd0;
    tick_pulse();
    cur_sec_zero = 1'b0;
    m_alarm_out = 1;
    total++;
    if (alarm_out !== 1'b1) begin
      bad++;
      $display("FAIL alarm_trigger: got %b want 1", alarm_out);
    end
    for (int k = 1; k <= ASECS; k++) begin
      repeat (2) step();
      tick_pulse();
      if (k == ASECS) m_alarm_out = 0;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL alarm_tick%0d: got out=%b want %b", k, alarm_out, m_alarm_out);
      end
    end
    cur_sec_zero = 1'b1;
    tick_pulse();
    cur_sec_zero = 1'b0;
    m_alarm_out = 1;
    total++;
    if (alarm_out !== 1'b1) begin
      bad++;
      $display("FAIL alarm_retrigger: got %b want 1", alarm_out);
    end
    press_btn(1, 0);
    total++;
    if (obs_vec() !== exp_vec() || m_state != 0) begin
      bad++;
      $display("FAIL alarm_silence: got %h want %h", obs_vec(), exp_vec());
    end
    press_btn(1, 0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL still_run_then_set_hour: got %h want %h", obs_vec(), exp_vec());
    end
    cur_sec_zero = 1'b1;
    tick_pulse();
    cur_sec_zero = 1'b0;
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL alarm_blocked_set_hour: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_set_hour();
    test_blink();
    test_alarm_min();
    test_simultaneous();
    test_random_alarm_set();
    test_alarm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
